msg_loader: RTL

Streaming message loader sitting directly upstream of the data memory write port. Accepts plaintext bytes over a valid/ready handshake and writes them into a contiguous data memory region, one byte per cycle. If the source ends early, the loader pads the rest of the region with the space character. While a load is in progress it owns the memory write port; the top level muxes its write outputs against the core's store path on Busy.

---
 rtl/msg_pkg.sv | 20 ++
 rtl/msg_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/msg_pkg.sv
// Shared types and constants for the message loader and core parity checks.
// Holds the loader FSM state encoding, pad/delimiter bytes and parity helper.
package msg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    localparam logic [7:0] SPACE_CHAR_DEFAULT = 8'h20;
    localparam logic [7:0] DELIM_CHAR         = 8'h00;

    // Even parity over the 7 data bits of an ASCII byte.
    function automatic logic parity7(input logic [6:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/msg_loader.sv
// Streaming message loader: writes source bytes into a memory region and
// pads with SPACE_CHAR on early end. Optional macro MSG_LOADER_PARITY_EN.
module msg_loader
    import msg_pkg::*;
#(
    parameter logic [7:0] SPACE_CHAR = SPACE_CHAR_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] BaseAddr,
    input  logic [7:0] Length,
    input  logic       InValid,
    input  logic [7:0] InData,
    input  logic       InLast,
    output logic       InReady,
    output logic       MemWriteEn,
    output logic [7:0] MemAddress,
    output logic [7:0] MemDataIn,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Count
);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [7:0] r_base;
    logic [7:0] r_len;
    logic [7:0] r_count;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_data;

    logic       w_accept;
    logic       w_pad_wr;
    logic       w_wr;
    logic       w_last_byte;
    logic       w_start_ok;
    logic [7:0] w_wbyte;
    logic [7:0] w_wdata;

    assign w_last_byte = ((r_count + 8'd1) == r_len);
    assign w_start_ok  = (r_state == IDLE) && Start;
    assign w_wr        = w_accept | w_pad_wr;

    assign MemWriteEn  = r_we;
    assign MemAddress  = r_addr;
    assign MemDataIn   = r_data;
    assign Count       = r_count;

    // State register; reset aborts any load in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; reaching Length outranks InLast.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next = (Length == 8'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    if (w_last_byte) begin
                        w_next = DONE;
                    end else if (InLast) begin
                        w_next = PAD;
                    end
                end
            end
            PAD: begin
                if (w_last_byte) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output decode; InReady depends on state only.
    always_comb begin
        InReady  = (r_state == LOAD);
        Busy     = (r_state != IDLE);
        Done     = (r_state == DONE);
        w_accept = (r_state == LOAD) && InValid;
        w_pad_wr = (r_state == PAD);
        w_wbyte  = w_pad_wr ? SPACE_CHAR : InData;
`ifdef MSG_LOADER_PARITY_EN
        w_wdata  = {parity7(w_wbyte[6:0]), w_wbyte[6:0]};
`else
        w_wdata  = w_wbyte;
`endif
    end

    // Registered write port, region capture and byte counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_base  <= 8'd0;
            r_len   <= 8'd0;
            r_count <= 8'd0;
            r_we    <= 1'b0;
            r_addr  <= 8'd0;
            r_data  <= 8'd0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_addr  <= r_base + r_count;
                r_data  <= w_wdata;
                r_count <= r_count + 8'd1;
            end
            if (w_start_ok) begin
                r_base  <= BaseAddr;
                r_len   <= Length;
                r_count <= 8'd0;
            end
        end
    end

endmodule
